// File: rtl/buffer_reader.sv
// Read-side controller for the inter-domain data buffer: pops one word per consume
// tick and holds it as data_2/data_valid_2 for the display multiplexer.
module buffer_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  rd_enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] data_2,
   output logic                  data_valid_2,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  busy,
   output logic                  tick_lost
);

   // state  | meaning
   // S_IDLE | no word displayed, waiting for a tick with data available
   // S_REQ  | pop strobe to the buffer asserted for this single cycle
   // S_WAIT | buffer read data arrives; captured on the exit edge
   // S_HOLD | word displayed; next tick pops again, retires, or is frozen
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

   state_t                state_q;
   logic                  rd_en_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  cnt_d;
   logic                  lost_q;
   logic                  pop_ok;

   assign pop_ok = tick & rd_enable & ~fifo_empty;
   assign cnt_d  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rd_en_q <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         lost_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop_ok) begin
                  state_q <= S_REQ;
                  rd_en_q <= 1'b1;
               end
            end
            S_REQ: begin
               state_q <= S_WAIT;
               rd_en_q <= 1'b0;
               if (tick) lost_q <= 1'b1;
            end
            S_WAIT: begin
               state_q <= S_HOLD;
               data_q  <= fifo_rd_data;
               valid_q <= 1'b1;
               cnt_q   <= cnt_d;
               if (tick) lost_q <= 1'b1;
            end
            S_HOLD: begin
               // rd_enable low freezes the displayed word; ticks are simply dropped
               if (tick && rd_enable) begin
                  if (!fifo_empty) begin
                     state_q <= S_REQ;
                     rd_en_q <= 1'b1;
                  end else begin
                     state_q <= S_IDLE;
                     valid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               rd_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_rd_en   = rd_en_q;
   assign data_2       = data_q;
   assign data_valid_2 = valid_q;
   assign rd_count     = cnt_q;
   assign tick_lost    = lost_q;
   assign busy         = (state_q == S_REQ) || (state_q == S_WAIT);

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader: table of per-cycle vectors plus hand-written
// sequences for reset mid-read, drain, and counter wrap (narrow counter instance).
module tb_buffer_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        rd_enable;
   logic        fifo_empty;
   logic [15:0] fifo_rd_data;
   logic        fifo_rd_en;
   logic [15:0] data_2;
   logic        data_valid_2;
   logic [7:0]  rd_count;
   logic        busy;
   logic        tick_lost;

   always #5 clk = ~clk;

   buffer_reader #(.DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .rd_enable    (rd_enable),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .data_2       (data_2),
      .data_valid_2 (data_valid_2),
      .rd_count     (rd_count),
      .busy         (busy),
      .tick_lost    (tick_lost)
   );

   // buffer model: read data appears one clock after the pop strobe
   logic [15:0] mem [1024];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_ptr % 1024];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] d);
      mem[wr_ptr % 1024] = d;
      wr_ptr++;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   typedef struct {
      bit          push;
      logic [15:0] pdat;
      bit          tk;
      bit          en;
      bit          e_rden;
      bit          e_busy;
      bit          e_valid;
      logic [15:0] e_data;
      logic [7:0]  e_cnt;
      bit          e_lost;
   } vec_t;

   vec_t vt [20];

   initial begin
      // push pdat, tick, en | rd_en busy valid data cnt lost (after the edge)
      vt[0]  = '{1'b1, 16'h0005, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 8'd0, 1'b0};
      vt[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 8'd0, 1'b0};
      vt[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0005, 8'd1, 1'b0};
      vt[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0005, 8'd1, 1'b0};
      vt[4]  = '{1'b1, 16'h00AB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0005, 8'd1, 1'b0};
      vt[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 8'd1, 1'b0};
      vt[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0005, 8'd1, 1'b0};
      vt[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00AB, 8'd2, 1'b0};
      vt[8]  = '{1'b1, 16'h0077, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AB, 8'd2, 1'b0};
      vt[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AB, 8'd2, 1'b0};
      vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AB, 8'd2, 1'b0};
      vt[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00AB, 8'd2, 1'b0};
      vt[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00AB, 8'd2, 1'b0};
      vt[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0077, 8'd3, 1'b0};
      vt[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0077, 8'd3, 1'b0};
      vt[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0077, 8'd3, 1'b0};
      vt[16] = '{1'b1, 16'h0009, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0077, 8'd3, 1'b0};
      vt[17] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0077, 8'd3, 1'b1};
      vt[18] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0009, 8'd4, 1'b1};
      vt[19] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0009, 8'd4, 1'b1};

      rst = 1'b1; tick = 1'b0; rd_enable = 1'b1;
      step(2);
      chk("reset rd_en", fifo_rd_en, 0);
      chk("reset data", data_2, 0);
      chk("reset valid", data_valid_2, 0);
      chk("reset cnt", rd_count, 0);
      chk("reset busy", busy, 0);
      chk("reset lost", tick_lost, 0);
      rst = 1'b0;
      step(1);

      for (int i = 0; i < 20; i++) begin
         if (vt[i].push) push(vt[i].pdat);
         tick = vt[i].tk;
         rd_enable = vt[i].en;
         step(1);
         chk($sformatf("v%0d rd_en", i), fifo_rd_en, vt[i].e_rden);
         chk($sformatf("v%0d busy", i), busy, vt[i].e_busy);
         chk($sformatf("v%0d valid", i), data_valid_2, vt[i].e_valid);
         chk($sformatf("v%0d data", i), data_2, vt[i].e_data);
         chk($sformatf("v%0d cnt", i), rd_count, vt[i].e_cnt);
         chk($sformatf("v%0d lost", i), tick_lost, vt[i].e_lost);
         tick = 1'b0;
      end

      // reset while the pop strobe is high: no capture may follow
      rd_enable = 1'b1;
      push(16'h1234);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      chk("midrst req rd_en", fifo_rd_en, 1);
      rst = 1'b1;
      step(1);
      chk("midrst rd_en", fifo_rd_en, 0);
      chk("midrst data", data_2, 0);
      chk("midrst valid", data_valid_2, 0);
      chk("midrst cnt", rd_count, 0);
      chk("midrst busy", busy, 0);
      chk("midrst lost", tick_lost, 0);
      rst = 1'b0;
      wr_ptr = rd_ptr;
      step(3);
      chk("midrst nocap valid", data_valid_2, 0);
      chk("midrst nocap data", data_2, 0);
      chk("midrst nocap cnt", rd_count, 0);

      // four pops 8 cycles apart, then drain on an empty tick
      push(16'd1); push(16'd1); push(16'd2); push(16'd3);
      for (int k = 0; k < 4; k++) begin
         logic [15:0] seq_exp;
         case (k)
            0, 1:    seq_exp = 16'd1;
            2:       seq_exp = 16'd2;
            default: seq_exp = 16'd3;
         endcase
         tick = 1'b1;
         step(1);
         tick = 1'b0;
         step(7);
         chk($sformatf("seq%0d data", k), data_2, seq_exp);
         chk($sformatf("seq%0d valid", k), data_valid_2, 1);
         chk($sformatf("seq%0d cnt", k), rd_count, k + 1);
      end
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      chk("drain valid", data_valid_2, 0);
      chk("drain data", data_2, 16'd3);
      chk("drain busy", busy, 0);
      chk("drain cond", fifo_empty & ~data_valid_2, 1);
      step(2);
      chk("drain no pop", fifo_rd_en, 0);
      chk("drain cnt", rd_count, 4);

      // counter wrap with the 8-bit instance: 256 pops from reset
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      wr_ptr = rd_ptr;
      for (int i = 0; i < 256; i++) push(16'h4000 + 16'(i));
      for (int i = 0; i < 256; i++) begin
         tick = 1'b1;
         step(1);
         tick = 1'b0;
         step(2);
         if (i == 254) begin
            chk("wrap pre cnt", rd_count, 8'hFF);
            chk("wrap pre data", data_2, 16'h40FE);
         end
      end
      chk("wrap cnt", rd_count, 8'h00);
      chk("wrap data", data_2, 16'h40FF);
      chk("wrap valid", data_valid_2, 1);
      chk("wrap lost", tick_lost, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/buffer_reader.md
Name: buffer_reader

Overview:
- Read-side controller for the inter-domain data buffer; the counterpart of the producer write path (data_1_en/data_1).
- Paced by a consume tick, it pops one word per tick from the buffer's read port and registers it as data_2/data_valid_2 for the display multiplexer.
- Drives the handshake the top FSM uses to leave the drain state: buffer empty and data_valid_2 low.

Parameters:
DATA_WIDTH, 16, width of buffer words and data_2
CNT_WIDTH, 16, width of the words-consumed counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active high
tick  input  1  single-cycle consume strobe (slow-clock edge, already edge-detected)
rd_enable  input  1  consumption allowed; low freezes the displayed word
fifo_empty  input  1  buffer read side has no words
fifo_rd_data  input  DATA_WIDTH  buffer read data; valid exactly 1 clk after fifo_rd_en
fifo_rd_en  output  1  one-cycle pop request to buffer
data_2  output  DATA_WIDTH  last consumed word, held for display
data_valid_2  output  1  data_2 holds a word not yet retired
rd_count  output  CNT_WIDTH  words consumed since reset
busy  output  1  high in S_REQ or S_WAIT
tick_lost  output  1  sticky: tick arrived while busy

Behaviour:
- Reset: synchronous, active high, on rising clk. Forces state=S_IDLE; fifo_rd_en=0, data_2=0, data_valid_2=0, rd_count=0, tick_lost=0. Overrides any transaction in flight, including a pending capture. Asserting rst in S_REQ drops fifo_rd_en at that edge.
- All outputs are registered. busy is decoded from the state register.
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD.
- S_IDLE:
  - data_valid_2=0.
  - On tick & rd_enable & !fifo_empty -> S_REQ.
  - Otherwise stay. A tick with empty buffer or rd_enable low is ignored.
- S_REQ:
  - fifo_rd_en=1 for exactly this one cycle.
  - Unconditionally -> S_WAIT.
- S_WAIT:
  - fifo_rd_en=0.
  - On exit edge: data_2<=fifo_rd_data, data_valid_2<=1, rd_count<=rd_count+1 -> S_HOLD.
- S_HOLD: data_2 and data_valid_2 are held. Action on tick:
  - rd_enable=0: stay, no change (frozen display).
  - rd_enable=1 & !fifo_empty: -> S_REQ. data_valid_2 stays 1 and data_2 keeps the old word until the new capture.
  - rd_enable=1 & fifo_empty: data_valid_2<=0 (data_2 retains value) -> S_IDLE.
- Latency:
  - tick sampled at edge N: fifo_rd_en high during cycle N+1.
  - New data_2/data_valid_2 visible after edge N+2.
  - Max one pop per tick; at most one outstanding read.
- Tick while busy: ignored for sequencing; sets tick_lost<=1. tick_lost is cleared only by rst.
- fifo_empty is sampled only at the tick decision. No other reader exists, so the buffer cannot empty between decision and pop.
- rd_count: modulo 2^CNT_WIDTH, wraps from all-ones to 0 with no flag.
- rd_enable dropping during S_REQ/S_WAIT does not abort the read; the word is captured, then held.
- Drain condition for the top FSM: fifo_empty & !data_valid_2 becomes true on the edge after the first tick that finds the buffer empty in S_HOLD.

Test Plan:
- Reset mid-read: assert rst during S_REQ -> next cycle fifo_rd_en=0, data_2=0, data_valid_2=0, rd_count=0, state S_IDLE; no capture occurs.
- Basic pop: buffer holds 0x0005, rd_enable=1, tick at edge N -> fifo_rd_en high only in cycle N+1; after edge N+2, data_2=0x0005, data_valid_2=1, rd_count=1.
- Sequence and drain: buffer holds 1,1,2,3, four ticks 8 cycles apart -> data_2 steps 1,1,2,3, rd_count=4. Fifth tick with empty buffer -> data_valid_2=0, data_2 stays 3, state S_IDLE.
- Freeze: in S_HOLD with data_2=0x00AB, rd_enable=0, two ticks -> no fifo_rd_en, data_2=0x00AB, data_valid_2=1. rd_enable=1 plus tick -> pop resumes.
- Tick while busy: second tick one cycle after the first -> exactly one fifo_rd_en pulse, tick_lost=1 stays set, rd_count=1.
- Counter wrap: preload by popping 65535 words then one more -> rd_count goes 0xFFFF to 0x0000; data path unaffected.
